// File: rtl/gen_reg_bank.sv
`default_nettype none
// ============================================================================
//  Module   : gen_reg_bank
//  Purpose  : Generic bank of NREG 32-bit registers behind a select/ack
//             handshake. Each register is one of three kinds:
//             read-write, read-only (fed from ro_data_in), or self-clearing
//             pulse. A select held high produces exactly one transaction.
//  Ports    : clk          - clock, rising edge
//             reset        - asynchronous, active-high
//             addr_ctrl    - [31:16] address, [1] 1=read/0=write, [0] select
//             data_in      - write data
//             data_out     - registered read data
//             ack          - transaction complete (high while in ACK)
//             err          - transaction rejected, qualified by ack
//             ro_data_in   - read-only sources, reg i at [32i+31:32i]
//             reg_data_out - current register contents, same packing
//             wr_strobe    - one-cycle pulse per accepted write
//  Revision : 1.0 - initial release
// ============================================================================
module gen_reg_bank #(
    parameter int unsigned     NREG       = 16,
    parameter logic [NREG-1:0] RO_MASK    = 16'h0002,
    parameter logic [NREG-1:0] PULSE_MASK = 16'h0000
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [31:0]          addr_ctrl,
    input  logic [31:0]          data_in,
    output logic [31:0]          data_out,
    output logic                 ack,
    output logic                 err,
    input  logic [NREG*32-1:0]   ro_data_in,
    output logic [NREG*32-1:0]   reg_data_out,
    output logic [NREG-1:0]      wr_strobe
);

    localparam logic [0:0] c_IDLE = 1'b0;
    localparam logic [0:0] c_ACK  = 1'b1;

    logic [0:0]          r_state;
    logic                r_err;
    logic [31:0]         r_data_out;
    logic [NREG-1:0]     r_wr_strobe;

    logic [15:0]         w_addr;
    logic                w_rd;
    logic                w_sel;
    logic                w_start;
    logic                w_addr_ok;
    logic                w_is_ro;
    logic                w_err;
    logic [31:0]         w_rd_sel;
    logic [31:0]         w_rd_data;
    logic [NREG-1:0]     w_wr_en;
    logic [NREG*32-1:0]  w_regs;
    logic                w_unused;

    assign w_addr  = addr_ctrl[31:16];
    assign w_rd    = addr_ctrl[1];
    assign w_sel   = addr_ctrl[0];
    assign w_start = (r_state == c_IDLE) && w_sel;

    // Full 16-bit compare so out-of-range addresses never alias onto a register.
    assign w_addr_ok = ({16'h0, w_addr} < NREG);

    // Bits of addr_ctrl with no meaning, and ro_data_in slices of writable
    // registers, are intentionally ignored.
    assign w_unused = ^{addr_ctrl[15:2], ro_data_in};

    always_comb begin
        w_rd_sel = 32'h0;
        w_is_ro  = 1'b0;
        for (int i = 0; i < int'(NREG); i++) begin
            if (w_addr == 16'(i)) begin
                w_rd_sel = w_regs[32*i +: 32];
                w_is_ro  = RO_MASK[i];
            end
        end
    end

    assign w_err     = ~w_addr_ok | (~w_rd & w_is_ro);
    assign w_rd_data = w_addr_ok ? w_rd_sel : (32'hBAD0_0000 | {16'h0, w_addr});

    // ------------------------------------------------------------------------
    // Register storage
    // ------------------------------------------------------------------------
    for (genvar i = 0; i < int'(NREG); i++) begin : g_reg
        logic [31:0] r_q;

        assign w_wr_en[i] = w_start & ~w_rd & (w_addr == 16'(i)) & ~RO_MASK[i];

        if (RO_MASK[i]) begin : g_ro
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    r_q <= 32'h0;
                end else begin
                    r_q <= ro_data_in[32*i +: 32];
                end
            end
        end else begin : g_rw
            // A pulse register holds written data for one cycle, then clears.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    r_q <= 32'h0;
                end else if (w_wr_en[i]) begin
                    r_q <= data_in;
                end else if (PULSE_MASK[i]) begin
                    r_q <= 32'h0;
                end
            end
        end

        assign w_regs[32*i +: 32] = r_q;
    end

    // ------------------------------------------------------------------------
    // Handshake FSM: one transaction per rising select, ack held until
    // select drops.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= c_IDLE;
            r_err       <= 1'b0;
            r_data_out  <= 32'h0;
            r_wr_strobe <= '0;
        end else begin
            // w_wr_en is only non-zero on the transaction edge.
            r_wr_strobe <= w_wr_en;
            case (r_state)
                c_IDLE: begin
                    if (w_sel) begin
                        r_state <= c_ACK;
                        r_err   <= w_err;
                        if (w_rd) begin
                            r_data_out <= w_rd_data;
                        end
                    end
                end
                c_ACK: begin
                    if (!w_sel) begin
                        r_state <= c_IDLE;
                    end
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

    assign ack          = (r_state == c_ACK);
    assign err          = r_err;
    assign data_out     = r_data_out;
    assign wr_strobe    = r_wr_strobe;
    assign reg_data_out = w_regs;

endmodule
`default_nettype wire

// File: tb/tb_gen_reg_bank.sv
`default_nettype none
// ============================================================================
//  Module   : tb_gen_reg_bank
//  Purpose  : Self-checking bench for gen_reg_bank (NREG=16, RO_MASK=0x0002,
//             PULSE_MASK=0x0004). Stimulus pushes the expected err/data_out
//             of each transaction into a queue; a monitor pops and compares
//             on every rising ack.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_gen_reg_bank;

    localparam int c_NREG = 16;

    logic                  clk;
    logic                  reset;
    logic [31:0]           addr_ctrl;
    logic [31:0]           data_in;
    logic [31:0]           data_out;
    logic                  ack;
    logic                  err;
    logic [c_NREG*32-1:0]  ro_data_in;
    logic [c_NREG*32-1:0]  reg_data_out;
    logic [c_NREG-1:0]     wr_strobe;

    typedef struct packed {
        logic        err;
        logic [31:0] dout;
    } exp_t;

    exp_t        sb_q[$];
    int          n_checks;
    int          n_fail;
    logic [31:0] m_dout;
    logic        r_prev_ack;

    gen_reg_bank #(
        .NREG       (c_NREG),
        .RO_MASK    (16'h0002),
        .PULSE_MASK (16'h0004)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .addr_ctrl    (addr_ctrl),
        .data_in      (data_in),
        .data_out     (data_out),
        .ack          (ack),
        .err          (err),
        .ro_data_in   (ro_data_in),
        .reg_data_out (reg_data_out),
        .wr_strobe    (wr_strobe)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] reg_of(input int a);
        return reg_data_out[32*a +: 32];
    endfunction

    // Monitor: compares every new ack against the oldest expectation.
    always @(negedge clk) begin
        if (reset) begin
            r_prev_ack = 1'b0;
        end else begin
            if (ack && !r_prev_ack) begin
                if (sb_q.size() == 0) begin
                    chk("sb_unexpected_ack", 32'(ack), 32'h0);
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    chk("sb_err", 32'(err), 32'(e.err));
                    chk("sb_data_out", data_out, e.dout);
                end
            end
            r_prev_ack = ack;
        end
    end

    // One transaction: select asserted for 'hold' cycles of ACK, data_in
    // changing every cycle after the first.
    task automatic txn(input logic [15:0] a, input logic rd, input logic [31:0] d,
                       input int hold, input logic exp_err, input logic [31:0] exp_rdata,
                       input logic [15:0] exp_strobe, input logic [31:0] exp_reg);
        @(negedge clk);
        addr_ctrl = {a, 14'h0, rd, 1'b1};
        data_in   = d;
        if (rd) m_dout = exp_rdata;
        sb_q.push_back('{err: exp_err, dout: m_dout});
        @(negedge clk);
        chk("ack_latency", 32'(ack), 32'h1);
        chk("wr_strobe_first", 32'(wr_strobe), 32'(exp_strobe));
        if (a < 16'(c_NREG)) chk("reg_after_txn", reg_of(int'(a)), exp_reg);
        for (int k = 1; k < hold; k++) begin
            data_in = d + 32'(k);
            @(negedge clk);
            chk("ack_held", 32'(ack), 32'h1);
            chk("wr_strobe_once", 32'(wr_strobe), 32'h0);
        end
        addr_ctrl[0] = 1'b0;
        @(negedge clk);
        chk("ack_drop", 32'(ack), 32'h0);
        chk("wr_strobe_clear", 32'(wr_strobe), 32'h0);
    endtask

    initial begin
        n_checks   = 0;
        n_fail     = 0;
        m_dout     = 32'h0;
        r_prev_ack = 1'b0;
        reset      = 1'b1;
        addr_ctrl  = 32'h0;
        data_in    = 32'h0;
        for (int i = 0; i < c_NREG; i++) ro_data_in[32*i +: 32] = 32'hDEAD_0000 | 32'(i);
        ro_data_in[32 +: 32] = 32'h1234_5678;

        #1;
        chk("rst_ack", 32'(ack), 32'h0);
        chk("rst_err", 32'(err), 32'h0);
        chk("rst_data_out", data_out, 32'h0);
        chk("rst_wr_strobe", 32'(wr_strobe), 32'h0);
        for (int i = 0; i < c_NREG; i++) chk("rst_reg", reg_of(i), 32'h0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("ro_tracks", reg_of(1), 32'h1234_5678);

        // Basic write then read-back
        txn(16'd3, 1'b0, 32'hCAFE_F00D, 1, 1'b0, 32'h0, 16'h0008, 32'hCAFE_F00D);
        txn(16'd3, 1'b1, 32'h0, 1, 1'b0, 32'hCAFE_F00D, 16'h0000, 32'hCAFE_F00D);

        // Read-only register: read succeeds, write rejected
        txn(16'd1, 1'b1, 32'h0, 1, 1'b0, 32'h1234_5678, 16'h0000, 32'h1234_5678);
        txn(16'd1, 1'b0, 32'hFFFF_FFFF, 1, 1'b1, 32'h0, 16'h0000, 32'h1234_5678);

        // Select held 10 cycles: only first-cycle data lands, one strobe
        txn(16'd4, 1'b0, 32'h1111_0000, 10, 1'b0, 32'h0, 16'h0010, 32'h1111_0000);
        chk("hold_reg4", reg_of(4), 32'h1111_0000);

        // Out-of-range read and an aliasing write attempt
        txn(16'h0020, 1'b1, 32'h0, 1, 1'b1, 32'hBAD0_0020, 16'h0000, 32'h0);
        txn(16'h0013, 1'b0, 32'h5555_5555, 1, 1'b1, 32'h0, 16'h0000, 32'h0);
        chk("noalias_reg3", reg_of(3), 32'hCAFE_F00D);
        chk("noalias_reg4", reg_of(4), 32'h1111_0000);

        // Pulse register: one cycle of visibility, reads 0 later
        txn(16'd2, 1'b0, 32'h0000_0001, 1, 1'b0, 32'h0, 16'h0004, 32'h0000_0001);
        chk("pulse_cleared", reg_of(2), 32'h0);
        repeat (3) @(negedge clk);
        txn(16'd2, 1'b1, 32'h0, 1, 1'b0, 32'h0, 16'h0000, 32'h0);

        // Reset while in ACK
        @(negedge clk);
        addr_ctrl = {16'd5, 14'h0, 1'b0, 1'b1};
        data_in   = 32'h5A5A_5A5A;
        sb_q.push_back('{err: 1'b0, dout: m_dout});
        @(negedge clk);
        chk("pre_rst_ack", 32'(ack), 32'h1);
        chk("pre_rst_reg5", reg_of(5), 32'h5A5A_5A5A);
        #2 reset = 1'b1;
        #1;
        chk("midrst_ack", 32'(ack), 32'h0);
        chk("midrst_err", 32'(err), 32'h0);
        chk("midrst_data_out", data_out, 32'h0);
        chk("midrst_strobe", 32'(wr_strobe), 32'h0);
        for (int i = 0; i < c_NREG; i++) chk("midrst_reg", reg_of(i), 32'h0);
        m_dout    = 32'h0;
        addr_ctrl = 32'h0;
        @(negedge clk);
        chk("rst_hold_ack", 32'(ack), 32'h0);
        reset = 1'b0;
        txn(16'd5, 1'b0, 32'h0BAD_CAFE, 1, 1'b0, 32'h0, 16'h0020, 32'h0BAD_CAFE);
        txn(16'd3, 1'b1, 32'h0, 1, 1'b0, 32'h0, 16'h0000, 32'h0);

        repeat (3) @(negedge clk);
        chk("sb_drained", 32'(sb_q.size()), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/gen_reg_bank.md
GEN_REG_BANK -- requirements
Module: gen_reg_bank

Interface
REQ-001 The block SHALL expose these parameters, one per line as name, default, meaning:
  - NREG, 16, number of 32-bit registers (2..256).
  - RO_MASK, 16'h0002, bit i=1 makes register i read-only, sourced from ro_data_in.
  - PULSE_MASK, 16'h0000, bit i=1 makes register i self-clearing.
REQ-002 The block SHALL have these ports, one per line as name, direction, width, meaning:
  - clk, input, 1, single clock; all logic on its rising edge.
  - reset, input, 1, asynchronous, active-high.
  - addr_ctrl, input, 32, [31:16]=register address, [1]=1 read / 0 write, [0]=select.
  - data_in, input, 32, write data.
  - data_out, output, 32, read data, registered.
  - ack, output, 1, transaction complete.
  - err, output, 1, transaction rejected, qualified by ack.
  - ro_data_in, input, NREG*32, read-only register sources, register i at [32i+31:32i].
  - reg_data_out, output, NREG*32, current register contents to chip, same packing.
  - wr_strobe, output, NREG, one-cycle pulse per accepted write.

Function
REQ-003 Read-only register i SHALL sample ro_data_in[i] every cycle, giving one cycle of latency and ignoring writes.
REQ-004 The FSM SHALL have two states: IDLE and ACK.
REQ-005 In IDLE with addr_ctrl[0]=1, the FSM SHALL execute exactly one transaction at that clock edge and enter ACK.
REQ-006 In ACK, ack SHALL be 1; the FSM SHALL remain in ACK while addr_ctrl[0]=1 and return to IDLE on the first edge with addr_ctrl[0]=0.
REQ-007 A select held high SHALL therefore cause one transaction only, and a new transaction SHALL require select to go low for at least one cycle.
REQ-008 Write accepted (address<NREG, RO_MASK bit=0): register updates to data_in at the transaction edge, wr_strobe[addr] is 1 for exactly the following cycle, err=0.
REQ-009 Read (address<NREG): data_out SHALL be loaded with the register's value before the transaction edge, so it is valid when ack first rises, with err=0.
REQ-010 data_out SHALL hold its value until the next read transaction.
REQ-011 Address>=NREG: no register SHALL change, no wr_strobe SHALL fire, err=1 with ack, and on a read data_out=32'hBAD0_0000 | {16'h0, addr}.
REQ-012 Write to a read-only register: contents SHALL be unchanged, no wr_strobe SHALL fire, err=1.
REQ-013 Pulse register (PULSE_MASK bit=1, writable): written bits SHALL be visible on reg_data_out for exactly one cycle, then the register SHALL return to 0.
REQ-014 A read of a pulse register SHALL return 0 except in the single cycle after a write.
REQ-015 err SHALL be updated only at transaction edges and SHALL hold until the next transaction.
REQ-016 ack SHALL rise exactly one cycle after the cycle in which select is first sampled high in IDLE, giving a latency of 1.
REQ-017 reg_data_out SHALL reflect register contents combinationally from the register outputs, with no extra latency.
REQ-018 Address decode SHALL compare all 16 address bits, with no aliasing for any NREG.

Reset
REQ-019 On reset assertion, independent of clk, the FSM SHALL go to IDLE and ack, err, wr_strobe and data_out SHALL go to 0.
REQ-020 On reset assertion, all writable registers SHALL go to 32'h0 and all read-only registers SHALL go to 32'h0.
REQ-021 Reset asserted mid-transaction SHALL abort it with no ack.
REQ-022 After reset release with select still high, the FSM SHALL start a new transaction on the first clock edge.
REQ-023 No output SHALL glitch to a non-reset value while reset=1.

Verification
REQ-024 NREG=16: write 32'hCAFE_F00D to addr 3 -> reg_data_out[3]=CAFEF00D, wr_strobe=16'h0008 for 1 cycle, ack 1 cycle after select, err=0; then read addr 3 -> data_out=CAFEF00D.
REQ-025 Hold select high 10 cycles on a write to addr 4 with data_in changing each cycle -> register holds the first-cycle data only, wr_strobe fires once, ack high until select drops.
REQ-026 ro_data_in[1]=32'h1234_5678: read addr 1 -> 12345678, err=0; write 32'hFFFF_FFFF to addr 1 -> err=1, register still tracks ro_data_in, no strobe.
REQ-027 Read addr 16'h0020 with NREG=16 -> ack=1, err=1, data_out=32'hBAD0_0020, no register changes.
REQ-028 PULSE_MASK=16'h0004: write 32'h0000_0001 to addr 2 -> reg_data_out[2]=1 for exactly one cycle, then 0; a read 3 cycles later returns 0.
REQ-029 Assert reset one cycle after a write's select rises, while in ACK -> ack=0 immediately, all registers 0, FSM in IDLE; after release with select low, the next write completes normally.
